// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//
// Purpose:
//   Log-structured barrel shifter with one pipeline stage per shift-amount
//   bit. Supports LSR, LSL, ROR, ROL and ASR, and reports the last bit
//   shifted or rotated out, a zero flag and an illegal-mode flag. A
//   valid/ready handshake is used on both sides. The whole pipeline freezes
//   while the result is stalled, and bubbles are held in place.
//
// Ports:
//   Clk           in   clock; all state changes on the rising edge
//   Rst_n         in   synchronous active-low reset
//   InValid       in   request valid
//   InReady       out  request accepted this cycle (low only while stalled)
//   ShiftSelect   in   000 LSR, 001 LSL, 010 ROR, 011 ROL, 100 ASR, others illegal
//   ShifterAmount in   shift distance, 0..WIDTH-1
//   OriginB       in   operand to shift
//   InTag         in   sideband tag, returned unmodified
//   OutValid      out  result valid
//   OutReady      in   consumer accepts the result
//   ShiftedB      out  shifted result
//   OutTag        out  tag of the returned result
//   CarryOut      out  last bit shifted or rotated out
//   Zero          out  ShiftedB == 0
//   Illegal       out  ShiftSelect was not a defined encoding
module pipelined_barrel_shifter #(
    parameter int  WIDTH   = 16,
    parameter int  TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               InValid,
    output logic               InReady,
    input  logic [2:0]         ShiftSelect,
    input  logic [SHAMT_W-1:0] ShifterAmount,
    input  logic [WIDTH-1:0]   OriginB,
    input  logic [TAG_W-1:0]   InTag,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   ShiftedB,
    output logic [TAG_W-1:0]   OutTag,
    output logic               CarryOut,
    output logic               Zero,
    output logic               Illegal
);

    localparam int LAST = SHAMT_W - 1;

    localparam logic [2:0] MODE_LSR = 3'b000;
    localparam logic [2:0] MODE_LSL = 3'b001;
    localparam logic [2:0] MODE_ROR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ASR = 3'b100;

    // A held result freezes every stage, so bubbles are never squeezed out.
    logic w_stall;

    assign w_stall = OutValid && !OutReady;
    assign InReady = !w_stall;

    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        localparam int STEP = 1 << gi;

        // Stage inputs: either the request ports or the previous stage.
        logic               w_in_valid;
        logic [WIDTH-1:0]   w_in_data;
        logic [2:0]         w_in_mode;
        logic [SHAMT_W-1:0] w_in_amt;
        logic               w_in_sign;
        logic               w_in_carry;
        logic               w_in_illegal;
        logic [TAG_W-1:0]   w_in_tag;

        logic [WIDTH-1:0]   w_fill;
        logic [WIDTH-1:0]   w_rot_r;
        logic [WIDTH-1:0]   w_rot_l;
        logic [WIDTH-1:0]   w_next_data;
        logic               w_next_carry;

        // Stage registers that reach the outputs or the next stage.
        logic               r_valid;
        logic [WIDTH-1:0]   r_data;
        logic               r_carry;
        logic               r_illegal;
        logic [TAG_W-1:0]   r_tag;

        if (gi == 0) begin : g_head
            // Illegal requests enter as zero data with no shifting, so they
            // come out as 0 / carry 0 / zero 1 with normal latency.
            assign w_in_valid   = InValid;
            assign w_in_illegal = (ShiftSelect > MODE_ASR);
            assign w_in_data    = w_in_illegal ? '0 : OriginB;
            assign w_in_mode    = ShiftSelect;
            assign w_in_amt     = ShifterAmount;
            assign w_in_sign    = OriginB[WIDTH-1];
            assign w_in_carry   = 1'b0;
            assign w_in_tag     = InTag;
        end else begin : g_body
            assign w_in_valid   = g_stage[gi-1].r_valid;
            assign w_in_illegal = g_stage[gi-1].r_illegal;
            assign w_in_data    = g_stage[gi-1].r_data;
            assign w_in_mode    = g_stage[gi-1].g_fwd.r_mode;
            assign w_in_amt     = g_stage[gi-1].g_fwd.r_amt;
            assign w_in_sign    = g_stage[gi-1].g_fwd.r_sign;
            assign w_in_carry   = g_stage[gi-1].r_carry;
            assign w_in_tag     = g_stage[gi-1].r_tag;
        end

        assign w_fill  = {WIDTH{w_in_sign}};
        assign w_rot_r = (w_in_data >> STEP) | (w_in_data << (WIDTH - STEP));
        assign w_rot_l = (w_in_data << STEP) | (w_in_data >> (WIDTH - STEP));

        // The amount travels pre-shifted, so bit 0 is always this stage's bit.
        always_comb begin
            w_next_data  = w_in_data;
            w_next_carry = w_in_carry;
            if (w_in_amt[0] && !w_in_illegal) begin
                case (w_in_mode)
                    MODE_LSR: begin
                        w_next_data  = w_in_data >> STEP;
                        w_next_carry = w_in_data[STEP-1];
                    end
                    MODE_ASR: begin
                        w_next_data  = (w_in_data >> STEP) | (w_fill << (WIDTH - STEP));
                        w_next_carry = w_in_data[STEP-1];
                    end
                    MODE_LSL: begin
                        w_next_data  = w_in_data << STEP;
                        w_next_carry = w_in_data[WIDTH-STEP];
                    end
                    MODE_ROR: begin
                        w_next_data  = w_rot_r;
                        w_next_carry = w_rot_r[WIDTH-1];
                    end
                    MODE_ROL: begin
                        w_next_data  = w_rot_l;
                        w_next_carry = w_rot_l[0];
                    end
                    default: begin
                        w_next_data  = w_in_data;
                        w_next_carry = w_in_carry;
                    end
                endcase
            end
        end

        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                r_valid   <= 1'b0;
                r_data    <= '0;
                r_carry   <= 1'b0;
                r_illegal <= 1'b0;
                r_tag     <= '0;
            end else if (!w_stall) begin
                r_valid   <= w_in_valid;
                r_data    <= w_next_data;
                r_carry   <= w_next_carry;
                r_illegal <= w_in_illegal;
                r_tag     <= w_in_tag;
            end
        end

        // Control fields only matter to later stages, so the last stage
        // does not keep them.
        if (gi < LAST) begin : g_fwd
            logic [2:0]         r_mode;
            logic [SHAMT_W-1:0] r_amt;
            logic               r_sign;

            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    r_mode <= '0;
                    r_amt  <= '0;
                    r_sign <= 1'b0;
                end else if (!w_stall) begin
                    r_mode <= w_in_mode;
                    r_amt  <= w_in_amt >> 1;
                    r_sign <= w_in_sign;
                end
            end
        end

        // Zero is registered next to the result so it reads 0 after reset.
        if (gi == LAST) begin : g_tail
            logic r_zero;

            always_ff @(posedge Clk) begin
                if (!Rst_n) begin
                    r_zero <= 1'b0;
                end else if (!w_stall) begin
                    r_zero <= (w_next_data == '0);
                end
            end
        end
    end

    assign OutValid = g_stage[LAST].r_valid;
    assign ShiftedB = g_stage[LAST].r_data;
    assign OutTag   = g_stage[LAST].r_tag;
    assign CarryOut = g_stage[LAST].r_carry;
    assign Illegal  = g_stage[LAST].r_illegal;
    assign Zero     = g_stage[LAST].g_tail.r_zero;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Testbench for pipelined_barrel_shifter (WIDTH=16, TAG_W=4).
// The expected results come from a queue-based reference model. The model
// derives each result from the shift definitions using whole-word
// arithmetic.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH   = 16;
    localparam int TAG_W   = 4;
    localparam int SHAMT_W = 4;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b0;
    logic               InValid = 1'b0;
    logic               InReady;
    logic [2:0]         ShiftSelect = 3'b000;
    logic [SHAMT_W-1:0] ShifterAmount = '0;
    logic [WIDTH-1:0]   OriginB = '0;
    logic [TAG_W-1:0]   InTag = '0;
    logic               OutValid;
    logic               OutReady = 1'b1;
    logic [WIDTH-1:0]   ShiftedB;
    logic [TAG_W-1:0]   OutTag;
    logic               CarryOut;
    logic               Zero;
    logic               Illegal;

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .InValid(InValid), .InReady(InReady),
        .ShiftSelect(ShiftSelect), .ShifterAmount(ShifterAmount),
        .OriginB(OriginB), .InTag(InTag),
        .OutValid(OutValid), .OutReady(OutReady),
        .ShiftedB(ShiftedB), .OutTag(OutTag),
        .CarryOut(CarryOut), .Zero(Zero), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_retired = 0;

    always @(posedge Clk) cyc++;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] tag;
        logic             carry;
        logic             zero;
        logic             ill;
    } exp_t;

    exp_t exp_q[$];

    // Reference: rotates via a doubled word, ASR via signed >>>, and carry
    // taken as the original bit that left last.
    function automatic exp_t model(logic [2:0] sel, int amt, logic [WIDTH-1:0] b,
                                   logic [TAG_W-1:0] tag);
        exp_t e;
        logic [2*WIDTH-1:0] dbl;
        e.tag   = tag;
        e.ill   = 1'b0;
        e.carry = 1'b0;
        e.res   = '0;
        case (sel)
            3'd0: begin
                e.res = b >> amt;
                if (amt > 0) e.carry = b[amt-1];
            end
            3'd1: begin
                e.res = b << amt;
                if (amt > 0) e.carry = b[WIDTH-amt];
            end
            3'd2: begin
                dbl   = {b, b} >> amt;
                e.res = dbl[WIDTH-1:0];
                if (amt > 0) e.carry = e.res[WIDTH-1];
            end
            3'd3: begin
                dbl   = {b, b} << amt;
                e.res = dbl[2*WIDTH-1:WIDTH];
                if (amt > 0) e.carry = e.res[0];
            end
            3'd4: begin
                e.res = WIDTH'($signed(b) >>> amt);
                if (amt > 0) e.carry = b[amt-1];
            end
            default: begin
                e.res = '0;
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: samples on the falling edge, half a cycle from any
    // active edge.
    exp_t             mon_e;
    logic             prev_stall = 1'b0;
    logic [25:0]      prev_out;

    always @(negedge Clk) begin
        if (Rst_n) begin
            check("inready", {31'd0, InReady}, {31'd0, !(OutValid && !OutReady)});
            if (prev_stall)
                check("stall_hold", {6'd0, OutValid, ShiftedB, OutTag, CarryOut, Zero, Illegal},
                      {6'd0, prev_out});
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_result: got tag %h data %h, expected no result",
                             OutTag, ShiftedB);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", {9'd0, ShiftedB, OutTag, CarryOut, Zero, Illegal},
                          {9'd0, mon_e.res, mon_e.tag, mon_e.carry, mon_e.zero, mon_e.ill});
                    n_retired++;
                    $display("retire tag=%h data=%h carry=%b zero=%b illegal=%b",
                             OutTag, ShiftedB, CarryOut, Zero, Illegal);
                end
            end
            if (InValid && InReady)
                exp_q.push_back(model(ShiftSelect, int'(ShifterAmount), OriginB, InTag));
            prev_stall = OutValid && !OutReady;
            prev_out   = {OutValid, ShiftedB, OutTag, CarryOut, Zero, Illegal};
        end else begin
            exp_q.delete();
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One isolated request into an idle pipeline; checks latency and
    // hand-computed result fields.
    task automatic run_one(string name, logic [2:0] sel, logic [3:0] amt, logic [15:0] b,
                           logic [3:0] tag, logic [15:0] x_res, logic x_carry,
                           logic x_zero, logic x_ill);
        int n;
        OutReady      = 1'b1;
        ShiftSelect   = sel;
        ShifterAmount = amt;
        OriginB       = b;
        InTag         = tag;
        InValid       = 1'b1;
        tick();
        InValid = 1'b0;
        n = 1;
        while (!OutValid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, 4);
        check(name, {9'd0, ShiftedB, OutTag, CarryOut, Zero, Illegal},
              {9'd0, x_res, tag, x_carry, x_zero, x_ill});
        tick();
    endtask

    // Holds one request until the falling-edge sample shows it accepted.
    task automatic issue(logic [2:0] sel, logic [3:0] amt, logic [15:0] b, logic [3:0] tag);
        logic acc;
        int   n;
        ShiftSelect   = sel;
        ShifterAmount = amt;
        OriginB       = b;
        InTag         = tag;
        InValid       = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 30) begin
            @(negedge Clk);
            acc = InReady;
            @(posedge Clk);
            #1;
            n++;
        end
        if (!acc) check("issue_timeout", 0, 1);
        InValid = 1'b0;
    endtask

    int base_retired;
    int k;

    initial begin
        // Reset state.
        Rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {6'd0, OutValid, ShiftedB, OutTag, CarryOut, Zero, Illegal}, 0);
        check("reset_inready", {31'd0, InReady}, 1);
        Rst_n = 1'b1;
        tick();

        // Model pinned to hand-computed literals.
        check("model_lsr", model(3'd0, 1, 16'h8001, 0).res, 16'h4000);
        check("model_rol", model(3'd3, 4, 16'h8001, 0).res, 16'h0018);
        check("model_asr_carry", model(3'd4, 15, 16'h8000, 0).carry, 0);
        check("model_ror_carry", model(3'd2, 1, 16'h0001, 0).carry, 1);

        // Directed cases with literal expectations.
        run_one("lsr",  3'd0, 4'd1,  16'h8001, 4'h1, 16'h4000, 1'b1, 1'b0, 1'b0);
        run_one("asr15",3'd4, 4'd15, 16'h8000, 4'h2, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_one("asr4", 3'd4, 4'd4,  16'h7FF0, 4'h3, 16'h07FF, 1'b0, 1'b0, 1'b0);
        run_one("lsl",  3'd1, 4'd1,  16'h8001, 4'h4, 16'h0002, 1'b1, 1'b0, 1'b0);
        run_one("rol",  3'd3, 4'd4,  16'h8001, 4'h5, 16'h0018, 1'b0, 1'b0, 1'b0);
        run_one("ror",  3'd2, 4'd1,  16'h0001, 4'h6, 16'h8000, 1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++)
            run_one("amt0", 3'(s), 4'd0, 16'hA5A5, 4'(s), 16'hA5A5, 1'b0, 1'b0, 1'b0);
        run_one("illegal", 3'b101, 4'd3, 16'hFFFF, 4'h9, 16'h0000, 1'b0, 1'b1, 1'b1);
        run_one("lsl_out", 3'd1, 4'd15, 16'h0003, 4'hA, 16'h8000, 1'b1, 1'b0, 1'b0);

        // Back-to-back burst with a 3-cycle stall after the first result.
        base_retired = n_retired;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(3'($urandom_range(0, 4)), 4'($urandom), 16'($urandom), 4'(i));
            end
            begin
                k = 0;
                while (!OutValid && k < 20) begin
                    tick();
                    k++;
                end
                if (!OutValid) check("burst_first_valid", 0, 1);
                OutReady = 1'b0;
                repeat (3) begin
                    tick();
                    check("stall_inready_low", {31'd0, InReady}, 0);
                end
                OutReady = 1'b1;
            end
        join
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        tick();
        check("burst_count", n_retired - base_retired, 6);
        check("burst_drained", exp_q.size(), 0);

        // Reset with three operations in flight.
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ShiftSelect   = 3'd1;
            ShifterAmount = 4'd2;
            OriginB       = 16'h1234 + 16'(i);
            InTag         = 4'(8 + i);
            InValid       = 1'b1;
            tick();
        end
        InValid = 1'b0;
        Rst_n   = 1'b0;
        tick();
        check("flush_outputs", {6'd0, OutValid, ShiftedB, OutTag, CarryOut, Zero, Illegal}, 0);
        Rst_n = 1'b1;
        repeat (8) begin
            tick();
            check("flush_no_stale", {31'd0, OutValid}, 0);
        end
        run_one("after_reset", 3'd0, 4'd4, 16'hBEEF, 4'hC, 16'h0BEE, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            InValid       = ($urandom_range(0, 3) != 0);
            ShiftSelect   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                                        : 3'($urandom_range(0, 4));
            ShifterAmount = 4'($urandom);
            OriginB       = 16'($urandom);
            InTag         = 4'($urandom);
            OutReady      = ($urandom_range(0, 3) != 0);
            tick();
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || OutValid) && k < 40) begin
            tick();
            k++;
        end
        check("random_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined barrel shifter for the datapath. It supports logical right/left, rotate right/left and arithmetic right shifts, and adds carry-out, zero and illegal-mode flags. It uses one log-shifter stage per shift-amount bit, with a registered valid/ready handshake on both sides. It sits between the operand-B register read and the ALU and replaces the single-cycle combinational shifter in wide or high-frequency configurations.

Parameters:
WIDTH, 16, data width in bits; must be a power of two and >= 2.
TAG_W, 4, width of the sideband tag carried alongside each operation.
SHAMT_W, $clog2(WIDTH), derived localparam (4 at default). Gives the shift-amount width and the number of pipeline stages.

Ports:
Clk  input  1  clock; all state updates on rising edge.
Rst_n  input  1  synchronous active-low reset.
InValid  input  1  request valid.
InReady  output  1  block accepts the request this cycle.
ShiftSelect  input  3  000 LSR, 001 LSL, 010 ROR, 011 ROL, 100 ASR, others illegal.
ShifterAmount  input  SHAMT_W  shift distance, 0..WIDTH-1.
OriginB  input  WIDTH  operand to shift.
InTag  input  TAG_W  sideband tag, returned unmodified.
OutValid  output  1  result valid.
OutReady  input  1  consumer accepts the result.
ShiftedB  output  WIDTH  shifted result.
OutTag  output  TAG_W  tag of the returned result.
CarryOut  output  1  last bit shifted or rotated out.
Zero  output  1  ShiftedB == 0.
Illegal  output  1  ShiftSelect was not a defined encoding.

Behaviour:
- Reset (Rst_n low at a rising edge): all stage valid bits cleared, all data/tag/flag registers cleared. OutValid, ShiftedB, OutTag, CarryOut, Zero and Illegal read 0 the following cycle. In-flight operations are discarded, not completed. InReady reads 1 once out of reset.
- Transfer on the input side: InValid && InReady at a rising edge. Transfer on the output side: OutValid && OutReady.
- Stall = OutValid && !OutReady. InReady = !Stall (combinational).
- When not stalled, every stage advances one step. Stage 0 loads the input, with valid = InValid. When stalled, all stages hold, including bubbles (no bubble collapsing).
- Latency: SHAMT_W cycles from accept to OutValid with no stall (4 at default). Throughput is one operation per cycle.
- Stage k (0..SHAMT_W-1) shifts by 2^k if amount bit k is set, otherwise it passes the data through. Stage k registers its result. The final stage's registers drive the outputs directly.
- Each stage also carries: mode, the remaining amount bits, the sign bit (captured from OriginB[WIDTH-1] at stage 0), carry, illegal and tag.
- Fill rules:
  - LSR/LSL fill with 0.
  - ASR fills with the captured sign bit.
  - ROR/ROL wrap bits around.
- Carry rules:
  - A stage that shifts sets carry to the last bit leaving that stage: LSR/ASR: data[2^k-1]; LSL: data[WIDTH-2^k]; ROR: new data[WIDTH-1]; ROL: new data[0].
  - A stage that does not shift keeps the incoming carry.
  - Carry enters stage 0 as 0, so amount 0 gives CarryOut 0.
- Amount 0: ShiftedB = OriginB for every legal mode.
- Illegal mode: ShiftedB = 0, CarryOut = 0, Illegal = 1, Zero = 1. The operation still occupies the pipeline with normal latency.
- Zero is computed in the final stage from the registered result.
- Simultaneous accept and retire while full: both happen in the same cycle; no loss and no duplication.
- OutValid and the result fields stay stable while stalled.

Test Plan:
- LSR, OriginB=0x8001, amount 1, OutReady=1 -> 4 cycles later OutValid=1, ShiftedB=0x4000, CarryOut=1, Zero=0.
- ASR, 0x8000 by 15 -> 0xFFFF, CarryOut=0. ASR, 0x7FF0 by 4 -> 0x07FF, CarryOut=0. LSL, 0x8001 by 1 -> 0x0002, CarryOut=1.
- ROL, 0x8001 by 4 -> 0x0018, CarryOut=0. ROR, 0x0001 by 1 -> 0x8000, CarryOut=1. Any mode with amount 0 on 0xA5A5 -> 0xA5A5, CarryOut=0.
- ShiftSelect=3'b101, OriginB=0xFFFF -> ShiftedB=0x0000, Zero=1, Illegal=1, CarryOut=0.
- Send 6 back-to-back requests with tags 0..5. Hold OutReady low for 3 cycles after the first OutValid -> InReady=0 during the stall, outputs held stable, all 6 results emerge in tag order with no loss or duplication.
- Assert Rst_n=0 for one cycle with 3 operations in flight -> next cycle OutValid=0 and all outputs 0, no stale result later appears, and a new request after reset returns correctly after 4 cycles.
